cdc_mailbox: RTL
================

CDC_MAILBOX -- requirements
Module: cdc_mailbox

Interface
REQ-001 SHALL have parameter WID_CMD, default 8, command word width.
REQ-002 SHALL have parameter WID_RSP, default 32, response word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, T_Clock cycles to wait for a response; 0 disables timeout.
REQ-004 SHALL have port T_Reset  in  1  transmitter-domain reset, asynchronous, active-low.
REQ-005 SHALL have port T_Clock  in  1  transmitter-domain clock.
REQ-006 SHALL have port R_Reset  in  1  receiver-domain reset, asynchronous, active-low.
REQ-007 SHALL have port R_Clock  in  1  receiver-domain clock.
REQ-008 SHALL have port T_Cmd  in  WID_CMD  command word, sampled on an accepted T_Start.
REQ-009 SHALL have port T_Start  in  1  one-T_Clock pulse requesting a transaction.
REQ-010 SHALL have port T_Busy  out  1  transaction in progress; T_Start is ignored while high.
REQ-011 SHALL have port T_Rsp  out  WID_RSP  registered response word, held until the next response.
REQ-012 SHALL have port T_RspValid  out  1  one-T_Clock pulse: T_Rsp updated.
REQ-013 SHALL have port T_Timeout  out  1  one-T_Clock pulse: response not received within TIMEOUT.
REQ-014 SHALL have port R_Cmd  out  WID_CMD  command word, stable while R_Pending or R_CmdValid is high.
REQ-015 SHALL have port R_CmdValid  out  1  one-R_Clock pulse: new command arrived.
REQ-016 SHALL have port R_Pending  out  1  command accepted by R side, awaiting response.
REQ-017 SHALL have port R_Rsp  in  WID_RSP  response word, sampled on an accepted R_RspStart.
REQ-018 SHALL have port R_RspStart  in  1  one-R_Clock pulse returning the response.

Function
REQ-019 SHALL carry T->R request and R->T acknowledge as toggle signals (T_Req, R_Ack), each crossing through the team's two-stage Synchronizer; no multi-bit signal SHALL be synchronized directly.
REQ-020 T-side FSM SHALL have states IDLE, WAIT, DRAIN; T_Busy SHALL be high exactly in WAIT and DRAIN.
REQ-021 IDLE: T_Start high -> T_Cmd captured into a T-domain command register, T_Req toggled, next state WAIT, all on the same T_Clock edge.
REQ-022 R side SHALL detect a change of synchronized T_Req against its previous registered value and assert R_CmdValid for exactly one R_Clock cycle, 2 to 3 R_Clock edges after T_Req toggles.
REQ-023 R_Cmd SHALL be driven directly from the T-domain command register, which SHALL not change while T_Busy is high.
REQ-024 R_Pending SHALL set on the edge where R_CmdValid is high and clear on the edge where R_RspStart is accepted.
REQ-025 R_RspStart SHALL be accepted when R_Pending or R_CmdValid is high; on acceptance, R_Rsp is captured into an R-domain response register and R_Ack is toggled on the same edge.
REQ-026 R_RspStart while neither R_Pending nor R_CmdValid is high SHALL be ignored, with no state change.
REQ-027 WAIT: detected change of synchronized R_Ack -> T_Rsp loaded from the R-domain response register, T_RspValid pulsed for one cycle, next state IDLE.
REQ-028 WAIT: a T-domain counter SHALL clear on entry and increment each cycle; when TIMEOUT is nonzero and the count reaches TIMEOUT-1 without an ack, T_Timeout SHALL pulse for one cycle and the next state SHALL be DRAIN.
REQ-029 An ack detected in the same cycle the count reaches TIMEOUT-1 SHALL take priority: T_RspValid pulses, T_Timeout does not.
REQ-030 DRAIN: the late ack SHALL be consumed without loading T_Rsp or pulsing T_RspValid, next state IDLE; this keeps the toggle pair aligned.
REQ-031 T_Start in WAIT or DRAIN SHALL be ignored and SHALL not be queued.
REQ-032 T_RspValid and T_Timeout SHALL never be high in the same cycle.

Reset
REQ-033 T_Reset low SHALL force: state IDLE, T_Req 0, T_Busy 0, T_Rsp 0, T_RspValid 0, T_Timeout 0, counter 0, ack edge-detect register 0, command register 0.
REQ-034 R_Reset low SHALL force: R_Ack 0, R_Pending 0, R_CmdValid 0, req edge-detect register 0, response register 0.
REQ-035 Both resets SHALL be asserted together; behaviour when only one domain is reset mid-transaction is undefined and not verified.

Verification
REQ-036 T_Clock 50 MHz, R_Clock 33 MHz; T_Cmd=0xA5 with T_Start pulse; R_RspStart with R_Rsp=0xDEADBEEF 4 R cycles after R_CmdValid -> R_Cmd=0xA5, single R_CmdValid pulse, T_Rsp=0xDEADBEEF, single T_RspValid pulse, T_Busy low afterwards.
REQ-037 T_Start again while T_Busy with T_Cmd=0x11 -> ignored; R_Cmd stays 0xA5, only one R_CmdValid.
REQ-038 TIMEOUT=16, R side never responds -> T_Timeout pulses 16 T cycles after WAIT entry; later R_RspStart with 0x1234 -> T_Rsp unchanged, no T_RspValid, T_Busy drops after the ack syncs.
REQ-039 R_RspStart in the same cycle as R_CmdValid with R_Rsp=0x55 -> accepted, R_Pending stays 0, T_Rsp=0x55.
REQ-040 Stray R_RspStart with no command outstanding -> no R_Ack toggle, no T-side activity.
REQ-041 Both resets asserted in WAIT -> all outputs return to REQ-033/034 values; the next transaction with T_Cmd=0x3C completes normally.

Source files
------------

// File: rtl/cdc_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdc_mailbox: single-entry command/response mailbox between two clock       |
// | domains, handshaking through a toggle request/acknowledge pair.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cdc_mailbox #(
    parameter int WID_CMD = 8,
    parameter int WID_RSP = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               T_Reset,
    input  logic               T_Clock,
    input  logic               R_Reset,
    input  logic               R_Clock,
    input  logic [WID_CMD-1:0] T_Cmd,
    input  logic               T_Start,
    output logic               T_Busy,
    output logic [WID_RSP-1:0] T_Rsp,
    output logic               T_RspValid,
    output logic               T_Timeout,
    output logic [WID_CMD-1:0] R_Cmd,
    output logic               R_CmdValid,
    output logic               R_Pending,
    input  logic [WID_RSP-1:0] R_Rsp,
    input  logic               R_RspStart
);

    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 1) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ---------------- transmitter domain ----------------
    state_t             state;
    state_t             state_nxt;
    logic               req_tog;
    logic [WID_CMD-1:0] cmd_reg;
    logic [WID_RSP-1:0] rsp_t;
    logic               rsp_valid;
    logic               timeout_pulse;
    logic [CNT_W-1:0]   cnt;
    logic               ack_meta;
    logic               ack_sync;
    logic               ack_prev;
    logic               ack_seen;
    logic               accept_start;
    logic               load_rsp;
    logic               fire_timeout;

    // ---------------- receiver domain ----------------
    logic               req_meta;
    logic               req_sync;
    logic               req_prev;
    logic               cmd_valid;
    logic               pending;
    logic               ack_tog;
    logic               rsp_accept;
    logic [WID_RSP-1:0] rsp_r;

    assign ack_seen = ack_sync ^ ack_prev;

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        load_rsp     = 1'b0;
        fire_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (T_Start) begin
                    accept_start = 1'b1;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the last counted cycle wins over the timeout
                if (ack_seen) begin
                    load_rsp  = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                    fire_timeout = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (ack_seen) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            req_tog       <= 1'b0;
            cmd_reg       <= '0;
            rsp_t         <= '0;
            rsp_valid     <= 1'b0;
            timeout_pulse <= 1'b0;
            cnt           <= '0;
            ack_meta      <= 1'b0;
            ack_sync      <= 1'b0;
            ack_prev      <= 1'b0;
        end else begin
            ack_meta      <= ack_tog;
            ack_sync      <= ack_meta;
            ack_prev      <= ack_sync;
            rsp_valid     <= load_rsp;
            timeout_pulse <= fire_timeout;
            if (accept_start) begin
                cmd_reg <= T_Cmd;
                req_tog <= ~req_tog;
            end
            // rsp_r is quiescent once its toggle has been seen here
            if (load_rsp) begin
                rsp_t <= rsp_r;
            end
            if (accept_start) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign T_Busy     = (state == WAIT) || (state == DRAIN);
    assign T_Rsp      = rsp_t;
    assign T_RspValid = rsp_valid;
    assign T_Timeout  = timeout_pulse;

    assign cmd_valid  = req_sync ^ req_prev;
    assign rsp_accept = R_RspStart && (pending || cmd_valid);

    always_ff @(posedge R_Clock or negedge R_Reset) begin
        if (!R_Reset) begin
            req_meta <= 1'b0;
            req_sync <= 1'b0;
            req_prev <= 1'b0;
            pending  <= 1'b0;
            ack_tog  <= 1'b0;
            rsp_r    <= '0;
        end else begin
            req_meta <= req_tog;
            req_sync <= req_meta;
            req_prev <= req_sync;
            if (rsp_accept) begin
                rsp_r   <= R_Rsp;
                ack_tog <= ~ack_tog;
                pending <= 1'b0;
            end else if (cmd_valid) begin
                pending <= 1'b1;
            end
        end
    end

    // cmd_reg is frozen for the whole transaction, so it can be read cross-domain
    assign R_Cmd      = cmd_reg;
    assign R_CmdValid = cmd_valid;
    assign R_Pending  = pending;

    a_no_dual_pulse: assert property (@(posedge T_Clock) disable iff (!T_Reset)
        !(T_RspValid && T_Timeout));

    a_cmdvalid_single: assert property (@(posedge R_Clock) disable iff (!R_Reset)
        R_CmdValid |=> !R_CmdValid);

endmodule
`default_nettype wire
